// File: rtl/slave_bus_ctrl.sv
// Bus-side slave access controller: decodes the master address to one of four slaves,
// strobes it until ack or timeout, drives the read-data mux select and returns a one-cycle ack.
module slave_bus_ctrl #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned SEL_HI  = 31,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m_req,
    input  logic              m_we,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [31:0]       m_wdata,
    output logic              m_ack,
    output logic              m_err,
    output logic [31:0]       m_rdata,
    output logic              m_busy,
    output logic [3:0]        s_strb,
    output logic              s_we,
    output logic [ADDR_W-1:0] s_addr,
    output logic [31:0]       s_wdata,
    input  logic [3:0]        s_ack,
    output logic [1:0]        mux_sel,
    input  logic [31:0]       mux_data
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ack_d, err_d, busy_d, we_d;
    logic [31:0]       rdata_d, wdata_d;
    logic [ADDR_W-1:0] addr_d;
    logic [3:0]        strb_d;
    logic [1:0]        sel_d, req_idx;

    assign req_idx = m_addr[SEL_HI -: 2];

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            m_ack   <= 1'b0;
            m_err   <= 1'b0;
            m_busy  <= 1'b0;
            m_rdata <= '0;
            s_strb  <= '0;
            s_we    <= 1'b0;
            s_addr  <= '0;
            s_wdata <= '0;
            mux_sel <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_ack   <= ack_d;
            m_err   <= err_d;
            m_busy  <= busy_d;
            m_rdata <= rdata_d;
            s_strb  <= strb_d;
            s_we    <= we_d;
            s_addr  <= addr_d;
            s_wdata <= wdata_d;
            mux_sel <= sel_d;
        end
    end

    // Next state and next output values
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdata_d = m_rdata;
        strb_d  = s_strb;
        we_d    = s_we;
        addr_d  = s_addr;
        wdata_d = s_wdata;
        sel_d   = mux_sel;

        case (state_q)
            IDLE: begin
                if (m_req) begin
                    addr_d  = m_addr;
                    we_d    = m_we;
                    wdata_d = m_wdata;
                    sel_d   = req_idx;
                    strb_d  = 4'(4'b0001 << req_idx);
                    cnt_d   = '0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // Counter exits at CNT_LAST, so it tops out at TIMEOUT and never wraps
                cnt_d = cnt_q + CNT_W'(1);
                if (s_ack[mux_sel]) begin
                    if (!s_we) begin
                        rdata_d = mux_data;
                    end
                    strb_d  = '0;
                    ack_d   = 1'b1;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    strb_d  = '0;
                    rdata_d = '0;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                strb_d  = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_slave_bus_ctrl.sv
// Self-checking bench for slave_bus_ctrl: directed test-plan cases plus randomized
// transactions checked against a transaction-level model of ack/timeout behaviour.
module tb_slave_bus_ctrl;

    localparam int unsigned TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ack;
    logic        m_err;
    logic [31:0] m_rdata;
    logic        m_busy;
    logic [3:0]  s_strb;
    logic        s_we;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_ack;
    logic [1:0]  mux_sel;
    logic [31:0] mux_data;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] model_rdata = 32'h0;

    slave_bus_ctrl #(.ADDR_W(32), .SEL_HI(31), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_ack    (m_ack),
        .m_err    (m_err),
        .m_rdata  (m_rdata),
        .m_busy   (m_busy),
        .s_strb   (s_strb),
        .s_we     (s_we),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_ack    (s_ack),
        .mux_sel  (mux_sel),
        .mux_data (mux_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One transaction. ack_cyc = strobe cycle in which the slave acks (0 or > TIMEOUT: never).
    task automatic run_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                           input int ack_cyc, input logic [31:0] rdat, input bit noise);
        logic [1:0] idx;
        logic [3:0] onehot;
        bit         exp_err;
        int         len;
        idx     = addr[31:30];
        onehot  = 4'(4'b0001 << idx);
        exp_err = !(ack_cyc >= 1 && ack_cyc <= int'(TIMEOUT));
        len     = exp_err ? int'(TIMEOUT) : ack_cyc;

        m_req = 1'b1; m_addr = addr; m_we = we; m_wdata = wdata; s_ack = 4'b0;
        @(posedge clk); @(negedge clk);
        for (int n = 1; n <= len; n++) begin
            chk("strb", 32'(s_strb), 32'(onehot));
            chk("busy_acc", 32'(m_busy), 32'd1);
            chk("ack_acc", 32'(m_ack), 32'd0);
            chk("s_addr", s_addr, addr);
            chk("s_wdata", s_wdata, wdata);
            chk("s_we", 32'(s_we), 32'(we));
            chk("mux_sel", 32'(mux_sel), 32'(idx));
            m_req = noise ? 1'($urandom) : 1'b0;
            if (noise) begin
                m_addr = $urandom; m_wdata = $urandom; m_we = 1'($urandom);
            end
            s_ack    = noise ? (4'($urandom) & ~onehot) : 4'b0;
            mux_data = $urandom;
            if (n == ack_cyc) begin
                s_ack    = s_ack | onehot;
                mux_data = rdat;
            end
            @(posedge clk); @(negedge clk);
        end

        if (exp_err) model_rdata = 32'h0;
        else if (!we) model_rdata = rdat;
        chk("m_ack", 32'(m_ack), 32'd1);
        chk("m_err", 32'(m_err), 32'(exp_err));
        chk("m_rdata", m_rdata, model_rdata);
        chk("strb_resp", 32'(s_strb), 32'd0);
        chk("busy_resp", 32'(m_busy), 32'd1);
        s_ack  = noise ? (4'($urandom) & ~onehot) : 4'b0;
        m_req  = noise ? 1'($urandom) : 1'b0;
        m_addr = $urandom;
        @(posedge clk); @(negedge clk);
        chk("ack_idle", 32'(m_ack), 32'd0);
        chk("err_idle", 32'(m_err), 32'd0);
        chk("busy_idle", 32'(m_busy), 32'd0);
        chk("strb_idle", 32'(s_strb), 32'd0);
        chk("sel_hold", 32'(mux_sel), 32'(idx));
        chk("addr_hold", s_addr, addr);
        chk("rdata_hold", m_rdata, model_rdata);
        m_req = 1'b0; s_ack = 4'b0;
    endtask

    initial begin
        rst_n = 1'b0; m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
        s_ack = 4'b0; mux_data = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ack", 32'(m_ack), 32'd0);
        chk("rst_busy", 32'(m_busy), 32'd0);
        chk("rst_strb", 32'(s_strb), 32'd0);
        chk("rst_sel", 32'(mux_sel), 32'd0);
        chk("rst_rdata", m_rdata, 32'd0);
        chk("rst_addr", s_addr, 32'd0);

        // Zero-wait read, wait-state write, timeout, ack on the boundary cycle, wrong-slave noise
        run_txn(32'h4000_0010, 1'b0, 32'h0, 1, 32'h1234_5678, 1'b0);
        run_txn(32'hC000_0004, 1'b1, 32'hCAFE_F00D, 5, 32'hDEAD_BEEF, 1'b0);
        run_txn(32'h8000_0020, 1'b0, 32'h0, 0, 32'h5555_AAAA, 1'b0);
        run_txn(32'h4000_0100, 1'b0, 32'h0, int'(TIMEOUT), 32'h0BAD_F00D, 1'b0);
        run_txn(32'h0000_0040, 1'b0, 32'h0, 7, 32'h7777_1111, 1'b1);

        // Reset during ACCESS drops the strobe at once and leaves no completion behind
        m_req = 1'b1; m_addr = 32'h8000_0000; m_we = 1'b0;
        @(posedge clk); @(negedge clk);
        m_req = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("mid_strb", 32'(s_strb), 32'h4);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_strb", 32'(s_strb), 32'd0);
        chk("mid_rst_busy", 32'(m_busy), 32'd0);
        chk("mid_rst_sel", 32'(mux_sel), 32'd0);
        chk("mid_rst_rdata", m_rdata, 32'd0);
        model_rdata = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("post_rst_ack", 32'(m_ack), 32'd0);
            chk("post_rst_busy", 32'(m_busy), 32'd0);
        end

        for (int t = 0; t < 40; t++) begin
            run_txn($urandom, 1'($urandom), $urandom, int'($urandom_range(0, TIMEOUT + 2)),
                    $urandom, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/slave_bus_ctrl.md
Name: slave_bus_ctrl

Overview:
- Bus-side controller sitting directly upstream of the 4:1 slave read-data mux on the DLX data-memory/peripheral bus.
- Decodes the master address into one of four slave indices, strobes the selected slave, waits for its ack with a timeout, and drives the mux select.
- Registers the muxed read data and returns a one-cycle ack (or error) to the master.

Parameters:
- ADDR_W, 32, master/slave address width.
- SEL_HI, 31, MSB of the 2-bit slave index field; index = m_addr[SEL_HI:SEL_HI-1].
- TIMEOUT, 15, maximum strobe cycles without ack before error; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m_req  in  1  master request; sampled only in IDLE.
- m_we  in  1  1 = write, 0 = read.
- m_addr  in  ADDR_W  master address.
- m_wdata  in  32  master write data.
- m_ack  out  1  one-cycle completion pulse.
- m_err  out  1  one-cycle timeout-error pulse, coincident with m_ack.
- m_rdata  out  32  registered read data.
- m_busy  out  1  high whenever state != IDLE.
- s_strb  out  4  one-hot slave strobe.
- s_we  out  1  latched write enable to slaves.
- s_addr  out  ADDR_W  latched address to slaves.
- s_wdata  out  32  latched write data to slaves.
- s_ack  in  4  per-slave ack; may be combinational in the strobe cycle.
- mux_sel  out  2  select driven to the slave read-data mux.
- mux_data  in  32  muxed read data returned from the slave mux.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values, applied asynchronously, including mid-transaction:
  - state = IDLE.
  - s_strb, m_ack, m_err, m_busy, s_we, wait counter = 0.
  - mux_sel = 2'b00.
  - m_rdata, s_addr, s_wdata = 0.
  - An in-flight strobe drops immediately.
- IDLE:
  - On m_req=1 at a clk edge, latch m_addr → s_addr, m_we → s_we, m_wdata → s_wdata.
  - Latch the index into mux_sel and a holding register.
  - Clear the wait counter and go to ACCESS.
  - With m_req=0, stay in IDLE; all latched outputs hold.
- ACCESS:
  - s_strb = one-hot(index) for every cycle in this state; the counter increments each cycle.
  - If s_ack[index]=1 at an edge, capture mux_data into m_rdata only when s_we=0 (m_rdata holds on writes), drop s_strb, and go to RESP with the error flag cleared.
  - If no ack and the counter equals TIMEOUT-1 (i.e. TIMEOUT strobe cycles elapsed), drop s_strb, set m_rdata = 0, set the error flag, and go to RESP.
  - Ack on the final cycle wins over timeout.
  - Acks on non-selected s_ack bits are ignored in every state.
- RESP:
  - m_ack=1 and m_err = error flag for exactly one cycle, then IDLE.
  - m_req is not sampled in RESP; a new request is accepted on the next IDLE edge.
- m_req, m_addr and m_wdata are ignored outside IDLE; the latched transaction cannot be altered.
- mux_sel holds the last accessed index until the next accepted request.
- Latency:
  - req edge → strobe high the next cycle.
  - Ack in the first strobe cycle → m_ack in the following cycle.
  - Minimum 2 cycles from the req-sampling edge to m_ack.
  - Back-to-back throughput: one transaction per 3 cycles.
- Counter width is 8 bits and must never wrap; it is cleared on every IDLE→ACCESS transition.
- m_busy = (state != IDLE), registered with the state.

Test Plan:
- Reset mid-ACCESS: request addr 0x8000_0000, assert rst_n=0 during the strobe → s_strb=0 and m_busy=0 immediately, mux_sel=0, no m_ack after release.
- Zero-wait read: addr 0x4000_0010, m_we=0, slave 1 acks combinationally with mux_data=0x1234_5678 → s_strb=4'b0010 in cycle 1, m_ack=1 with m_rdata=0x1234_5678 and m_err=0 in cycle 2, mux_sel=01.
- Wait-state write: addr 0xC000_0004, wdata 0xCAFE_F00D, slave 3 acks after 5 strobe cycles → s_wdata=0xCAFE_F00D throughout, m_ack one cycle after ack, m_rdata unchanged.
- Timeout: TIMEOUT=15, request slave 2 with no ack → strobe high exactly 15 cycles, then m_ack=1, m_err=1, m_rdata=0; return to IDLE.
- Ack on boundary: slave acks in the 15th strobe cycle → m_err=0 and data captured.
- Wrong-slave ack and request during busy: request slave 0, pulse s_ack[2] and toggle m_req/m_addr while busy → no completion until s_ack[0]; the latched address is unchanged.
